// File: rtl/data_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : data_pack_if
// Purpose  : Bundles the packet-side and word-side handshake signals of the
//            data_pack packer. The producer/consumer side uses the master
//            modport; the packer itself uses the slave modport.
// Signals  : pkt_in/pkt_valid/pkt_ready   packet stream (producer -> packer)
//            flush                        request to emit the residual word
//            word_out/word_valid/word_ready/word_last  word stream
//            fill                         residual bit count in accumulator
// Revision : 1.0 - initial release
// ============================================================================
interface data_pack_if #(
    parameter int DATA_BITWIDTH = 5,
    parameter int PACKET_SIZE   = 7
);
    localparam int C_DATA_SIZE = 2 ** DATA_BITWIDTH;

    logic [PACKET_SIZE-1:0]   pkt_in;
    logic                     pkt_valid;
    logic                     pkt_ready;
    logic                     flush;
    logic [C_DATA_SIZE-1:0]   word_out;
    logic                     word_valid;
    logic                     word_ready;
    logic                     word_last;
    logic [DATA_BITWIDTH-1:0] fill;

    // Producer / consumer side (testbench or surrounding logic).
    modport master (
        output pkt_in,
        output pkt_valid,
        input  pkt_ready,
        output flush,
        input  word_out,
        input  word_valid,
        output word_ready,
        input  word_last,
        input  fill
    );

    // Packer side.
    modport slave (
        input  pkt_in,
        input  pkt_valid,
        output pkt_ready,
        input  flush,
        output word_out,
        output word_valid,
        input  word_ready,
        output word_last,
        output fill
    );
endinterface
`default_nettype wire

// File: rtl/data_pack.sv
`default_nettype none
// ============================================================================
// Module   : data_pack
// Purpose  : Packs fixed-width packets LSB-first into a continuous bit stream
//            and emits it as full-width words. Packet k lands at stream bits
//            [PACKET_SIZE*k +: PACKET_SIZE]; word n is stream bits
//            [DATA_SIZE*n +: DATA_SIZE]. A level flush emits the residual
//            bits as a zero-padded final word tagged with word_last.
// Ports    : clk          clock, rising edge
//            rst          asynchronous active-high reset
//            bus (slave)  packet input, flush, word output handshake, fill
// Revision : 1.0 - initial release
// ============================================================================
module data_pack #(
    parameter int DATA_BITWIDTH = 5,
    parameter int PACKET_SIZE   = 7
) (
    input  wire logic   clk,
    input  wire logic   rst,
    data_pack_if.slave  bus
);

    localparam int C_DATA_SIZE = 2 ** DATA_BITWIDTH;
    // Worst case the accumulator holds DATA_SIZE-1 residual bits plus one
    // freshly merged packet.
    localparam int C_ACC_W     = C_DATA_SIZE + PACKET_SIZE - 1;
    // fill + PACKET_SIZE needs one extra bit to detect a completed word.
    localparam int C_SUM_W     = DATA_BITWIDTH + 1;

    localparam logic [C_SUM_W-1:0] C_PKT_SIZE_S  = C_SUM_W'(PACKET_SIZE);
    localparam logic [C_SUM_W-1:0] C_DATA_SIZE_S = C_SUM_W'(C_DATA_SIZE);

    typedef enum logic [0:0] {
        PHASE_PACK  = 1'b0,
        PHASE_FLUSH = 1'b1
    } phase_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    phase_t                    r_phase;
    logic [C_ACC_W-1:0]        r_acc;
    logic [DATA_BITWIDTH-1:0]  r_fill;
    logic [C_DATA_SIZE-1:0]    r_word_out;
    logic                      r_word_valid;
    logic                      r_word_last;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                      w_slot_free;
    logic                      w_pkt_ready;
    logic                      w_accept;
    logic                      w_take;
    logic [C_ACC_W-1:0]        w_merged;
    logic [C_ACC_W-1:0]        w_shifted;
    logic [C_SUM_W-1:0]        w_sum;
    logic                      w_word_done;
    logic                      w_flush_emit;
    logic [C_DATA_SIZE-1:0]    w_fill_mask;
    logic [C_DATA_SIZE-1:0]    w_flush_word;

    // The output register can take a new word when empty or when its
    // current word is being consumed this very cycle.
    assign w_slot_free = ~r_word_valid | bus.word_ready;
    assign w_take      = r_word_valid & bus.word_ready;

    // Combinational from rst, flush and word_ready so that a word being
    // drained and a packet being accepted can share one edge.
    assign w_pkt_ready = ~rst & ~bus.flush & w_slot_free & (r_phase == PHASE_PACK);
    assign w_accept    = bus.pkt_valid & w_pkt_ready;

    // Bits at or above r_fill are always zero, so OR-ing the shifted packet
    // in is equivalent to writing the field [fill +: PACKET_SIZE].
    assign w_merged    = r_acc | (C_ACC_W'(bus.pkt_in) << r_fill);
    assign w_shifted   = w_merged >> C_DATA_SIZE;

    assign w_sum       = {1'b0, r_fill} + C_PKT_SIZE_S;
    assign w_word_done = (w_sum >= C_DATA_SIZE_S);

    // Flushed word: residual bits only, everything above fill forced low.
    assign w_fill_mask  = (C_DATA_SIZE'(1) << r_fill) - C_DATA_SIZE'(1);
    assign w_flush_word = r_acc[C_DATA_SIZE-1:0] & w_fill_mask;
    assign w_flush_emit = bus.flush & (r_fill != '0) & w_slot_free;

    // ------------------------------------------------------------------
    // Sequential state: phase, accumulator, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= PHASE_PACK;
            r_acc        <= '0;
            r_fill       <= '0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_word_last  <= 1'b0;
        end else begin
            // Phase simply tracks the flush level; leaving FLUSH costs one
            // cycle of blocked input after flush drops.
            r_phase <= bus.flush ? PHASE_FLUSH : PHASE_PACK;

            // Consumed word clears; a load below overrides this so words
            // can stream back-to-back.
            if (w_take) begin
                r_word_valid <= 1'b0;
                r_word_last  <= 1'b0;
            end

            if (w_accept) begin
                // sum is at most 2*DATA_SIZE-1, so sum-DATA_SIZE equals the
                // low DATA_BITWIDTH bits of sum whenever a word completes;
                // the same slice is the new fill in both branches.
                r_fill <= w_sum[DATA_BITWIDTH-1:0];
                if (w_word_done) begin
                    r_word_out   <= w_merged[C_DATA_SIZE-1:0];
                    r_word_valid <= 1'b1;
                    r_word_last  <= 1'b0;
                    r_acc        <= w_shifted;
                end else begin
                    r_acc        <= w_merged;
                end
            end else if (w_flush_emit) begin
                r_word_out   <= w_flush_word;
                r_word_valid <= 1'b1;
                r_word_last  <= 1'b1;
                r_acc        <= '0;
                r_fill       <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pkt_ready  = w_pkt_ready;
    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.word_last  = r_word_last;
    assign bus.fill       = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_data_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_pack
// Purpose  : Self-checking bench for data_pack. A reference model packs
//            accepted packets into expected words held in a scoreboard queue;
//            directed steps cover reset, packing, flush, backpressure, a
//            randomly stalled stream with round-trip unpacking, and an
//            asynchronous reset in mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_pack;

    localparam int DBW = 5;
    localparam int PS  = 7;
    localparam int DS  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    data_pack_if #(.DATA_BITWIDTH(DBW), .PACKET_SIZE(PS)) bus ();

    data_pack #(.DATA_BITWIDTH(DBW), .PACKET_SIZE(PS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    // ------------------------------------------------------------------
    // Reference model + scoreboard, evaluated at each falling edge for
    // the rising edge that follows.
    // ------------------------------------------------------------------
    logic [63:0] m_acc   = '0;
    int          m_fill  = 0;
    bit          m_wv    = 1'b0;
    bit          m_phase = 1'b0;
    bit          m_slot;
    bit          m_ready;
    logic [32:0] sb[$];       // {last, word}
    logic [31:0] got[$];      // every word the consumer took

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'd0);
            m_acc   = '0;
            m_fill  = 0;
            m_wv    = 1'b0;
            m_phase = 1'b0;
            sb.delete();
        end else begin
            m_slot  = !m_wv || bus.word_ready;
            m_ready = !bus.flush && m_slot && !m_phase;

            chk("pkt_ready",  64'(bus.pkt_ready),  64'(m_ready));
            chk("word_valid", 64'(bus.word_valid), 64'(m_wv));
            chk("fill",       64'(bus.fill),       64'(m_fill));
            if (m_wv) begin
                if (sb.size() == 0) begin
                    timeout("scoreboard_empty");
                end else begin
                    chk("word_out",  64'(bus.word_out),  64'(sb[0][31:0]));
                    chk("word_last", 64'(bus.word_last), 64'(sb[0][32]));
                end
            end

            if (m_wv && bus.word_ready) begin
                got.push_back(bus.word_out);
                if (sb.size() > 0) sb.delete(0);
                m_wv = 1'b0;
            end
            if (bus.pkt_valid && m_ready) begin
                m_acc  = m_acc | (64'(bus.pkt_in) << m_fill);
                m_fill = m_fill + PS;
                if (m_fill >= DS) begin
                    sb.push_back({1'b0, m_acc[31:0]});
                    m_acc  = m_acc >> DS;
                    m_fill = m_fill - DS;
                    m_wv   = 1'b1;
                end
            end else if (bus.flush && m_fill > 0 && m_slot) begin
                sb.push_back({1'b1, m_acc[31:0] & ((32'd1 << m_fill) - 32'd1)});
                m_acc  = '0;
                m_fill = 0;
                m_wv   = 1'b1;
            end
            m_phase = bus.flush;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one packet until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [PS-1:0] p, input bit stall);
        bit acc;
        int t;
        t = 0;
        bus.pkt_in    = p;
        bus.pkt_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            acc = bus.pkt_ready;
            @(posedge clk);
            #1;
            if (stall) bus.word_ready = ($urandom_range(0, 2) != 0);
            if (acc) break;
            t++;
            if (t > 200) begin
                timeout("send");
                break;
            end
        end
        bus.pkt_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.word_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        bit done;
        done = 1'b0;
        bus.word_ready = 1'b1;
        bus.flush      = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.fill == '0 && !bus.word_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("flush");
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        tick(1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [PS-1:0]  sent[$];
    logic [223:0]   stream;
    int             n0;

    initial begin
        bus.pkt_in     = '0;
        bus.pkt_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b1;

        // Reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("reset_word_out",   64'(bus.word_out),   64'd0);
        chk("reset_word_valid", 64'(bus.word_valid), 64'd0);
        chk("reset_word_last",  64'(bus.word_last),  64'd0);
        chk("reset_fill",       64'(bus.fill),       64'd0);
        chk("reset_pkt_ready",  64'(bus.pkt_ready),  64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("release_pkt_ready", 64'(bus.pkt_ready), 64'd1);
        tick(1);

        // Packets 1..5 form a single word.
        for (int i = 1; i <= 5; i++) send(PS'(i), 1'b0);
        chk("seq_word_out",   64'(bus.word_out),   64'h5080C101);
        chk("seq_word_valid", 64'(bus.word_valid), 64'd1);
        chk("seq_word_last",  64'(bus.word_last),  64'd0);
        chk("seq_fill",       64'(bus.fill),       64'd3);
        tick(1);
        chk("seq_drained", 64'(bus.word_valid), 64'd0);
        do_flush();

        // Five all-ones packets, then flush the three residual ones.
        for (int i = 0; i < 5; i++) send(7'h7F, 1'b0);
        chk("ones_word_out", 64'(bus.word_out), 64'hFFFFFFFF);
        chk("ones_fill",     64'(bus.fill),     64'd3);
        bus.flush = 1'b1;
        tick(1);
        chk("flush_word_out",   64'(bus.word_out),   64'h7);
        chk("flush_word_last",  64'(bus.word_last),  64'd1);
        chk("flush_word_valid", 64'(bus.word_valid), 64'd1);
        chk("flush_fill",       64'(bus.fill),       64'd0);
        tick(1);
        bus.flush = 1'b0;
        tick(1);

        // Backpressure: consumer stalls when the first word completes.
        bus.word_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(PS'(i), 1'b0);
        bus.pkt_in    = 7'h11;
        bus.pkt_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_pkt_ready", 64'(bus.pkt_ready), 64'd0);
            chk("bp_word_out",  64'(bus.word_out),  64'h5080C101);
            chk("bp_fill",      64'(bus.fill),      64'd3);
        end
        @(posedge clk);
        #1 bus.word_ready = 1'b1;
        tick(1);
        bus.pkt_valid = 1'b0;
        chk("bp_release_valid", 64'(bus.word_valid), 64'd0);
        chk("bp_resume_fill",   64'(bus.fill),       64'd10);
        do_flush();

        // 32 random packets with a randomly stalling consumer.
        n0 = got.size();
        sent.delete();
        for (int k = 0; k < 32; k++) begin
            sent.push_back(PS'($urandom));
            send(sent[k], 1'b1);
        end
        wait_idle();
        chk("rand_word_count", 64'(got.size() - n0), 64'd7);
        chk("rand_fill",       64'(bus.fill),        64'd0);
        if (got.size() - n0 >= 7) begin
            for (int w = 0; w < 7; w++) stream[32*w +: 32] = got[n0 + w];
            for (int k = 0; k < 32; k++)
                chk("rand_roundtrip", 64'(stream[PS*k +: PS]), 64'(sent[k]));
        end

        // Asynchronous reset in mid-stream discards residual bits.
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b0);
        chk("pre_rst_fill", 64'(bus.fill), 64'd14);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_fill",      64'(bus.fill),      64'd0);
        chk("async_rst_pkt_ready", 64'(bus.pkt_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);
        n0 = got.size();
        bus.flush = 1'b1;
        tick(5);
        bus.flush = 1'b0;
        tick(1);
        chk("post_rst_flush_words", 64'(got.size() - n0), 64'd0);
        for (int i = 0; i < 5; i++) send(7'h7F, 1'b0);
        chk("post_rst_word_out", 64'(bus.word_out), 64'hFFFFFFFF);
        wait_idle();
        do_flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
